// File: rtl/ncl_dr_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// ncl_dr_ctrl_decoder
//
// Clocked dual-rail (NCL-style) opcode decoder with a four-phase ki/ko
// handshake. A complete DATA opcode is decoded into a dual-rail select field
// and a dual-rail operation flag. The outputs hold until a complete NULL
// returns the block to its NULL state.
//
// Opcode layout (dual-rail bit pairs):
//   [OP_W-1:OP_W-2]          class : 10 -> op=0, 01 -> op=1, 00/11 illegal
//   [OP_W-3:OP_W-2-SEL_W]    select field, copied rail for rail
//   below that               must be complete, value ignored
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_t / in_f      opcode true / false rails
//   ki               downstream request (1 = ready for DATA, 0 = for NULL)
//   ko               upstream request   (1 = ready for DATA, 0 = for NULL)
//   sel_t / sel_f    decoded select rails
//   op_t / op_f      decoded op flag rails
//   err_rail         sticky: some input bit had both rails high
//   err_op           sticky: an illegal class was decoded
//   dec_cnt          number of completed DATA decodes (wraps)
//
// Optional feature (macro NCL_IN_SYNC_EN):
//   defined   - in_t, in_f and ki each pass through a 2-flop synchroniser
//               before classification (3-clock input-to-output latency).
//   undefined - inputs are used directly and must be synchronous to clk
//               (1-clock latency).
// ---------------------------------------------------------------------------
module ncl_dr_ctrl_decoder #(
    parameter int OP_W  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  in_t,
    input  logic [OP_W-1:0]  in_f,
    input  logic             ki,
    output logic             ko,
    output logic [SEL_W-1:0] sel_t,
    output logic [SEL_W-1:0] sel_f,
    output logic             op_t,
    output logic             op_f,
    output logic             err_rail,
    output logic             err_op,
    output logic [CNT_W-1:0] dec_cnt
);

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_DATA = 2'd1,
        S_BAD  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic [OP_W-1:0] in_t_s;
    logic [OP_W-1:0] in_f_s;
    logic            ki_s;

`ifdef NCL_IN_SYNC_EN
    logic [OP_W-1:0] in_t_s1_q, in_t_s2_q;
    logic [OP_W-1:0] in_f_s1_q, in_f_s2_q;
    logic            ki_s1_q,   ki_s2_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its pre-edge value, making the two stages a real pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_t_s1_q <= '0;
            in_t_s2_q <= '0;
            in_f_s1_q <= '0;
            in_f_s2_q <= '0;
            ki_s1_q   <= 1'b0;
            ki_s2_q   <= 1'b0;
        end else begin
            in_t_s1_q <= in_t;
            in_t_s2_q <= in_t_s1_q;
            in_f_s1_q <= in_f;
            in_f_s2_q <= in_f_s1_q;
            ki_s1_q   <= ki;
            ki_s2_q   <= ki_s1_q;
        end
    end

    assign in_t_s = in_t_s2_q;
    assign in_f_s = in_f_s2_q;
    assign ki_s   = ki_s2_q;
`else
    assign in_t_s = in_t;
    assign in_f_s = in_f;
    assign ki_s   = ki;
`endif

    // -----------------------------------------------------------------------
    // Input classification
    // -----------------------------------------------------------------------
    logic             in_ill;
    logic             in_data;
    logic             in_null;
    logic [1:0]       cls;
    logic             cls_ok;
    logic [SEL_W-1:0] sel_val;

    assign in_ill  = |(in_t_s & in_f_s);
    // With no bit double-high, XOR of the rails is 1 exactly where one rail is set.
    assign in_data = !in_ill && (&(in_t_s ^ in_f_s));
    assign in_null = ~|(in_t_s | in_f_s);
    // In a complete DATA word the true rails carry the opcode value.
    assign cls     = in_t_s[OP_W-1 -: 2];
    assign cls_ok  = cls[1] ^ cls[0];
    assign sel_val = in_t_s[OP_W-3 -: SEL_W];

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_t_q, sel_t_d;
    logic [SEL_W-1:0] sel_f_q, sel_f_d;
    logic             op_t_q, op_t_d;
    logic             op_f_q, op_f_d;
    logic             ko_q, ko_d;
    logic             err_rail_q, err_rail_d;
    logic             err_op_q, err_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NULL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every register here, including the counter, gets a reset value so
    // an asynchronous rst immediately drives NULL and a clean handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_t_q    <= '0;
            sel_f_q    <= '0;
            op_t_q     <= 1'b0;
            op_f_q     <= 1'b0;
            ko_q       <= 1'b1;
            err_rail_q <= 1'b0;
            err_op_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sel_t_q    <= sel_t_d;
            sel_f_q    <= sel_f_d;
            op_t_q     <= op_t_d;
            op_f_q     <= op_f_d;
            ko_q       <= ko_d;
            err_rail_q <= err_rail_d;
            err_op_q   <= err_op_d;
            cnt_q      <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. An illegal input freezes the FSM.
    // -----------------------------------------------------------------------
    // NOTE: each always_comb assigns its outputs a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!in_ill) begin
            case (state_q)
                S_NULL:  if (in_data && ki_s)  state_d = cls_ok ? S_DATA : S_BAD;
                S_DATA:  if (in_null && !ki_s) state_d = S_NULL;
                S_BAD:   if (in_null)          state_d = S_NULL;
                default:                       state_d = S_NULL;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs. All rails change
    // together on the transition edge, so the outputs are never partial.
    // -----------------------------------------------------------------------
    always_comb begin
        sel_t_d    = sel_t_q;
        sel_f_d    = sel_f_q;
        op_t_d     = op_t_q;
        op_f_d     = op_f_q;
        ko_d       = ko_q;
        err_rail_d = err_rail_q | in_ill;
        err_op_d   = err_op_q;
        cnt_d      = cnt_q;
        if (!in_ill) begin
            case (state_q)
                S_NULL: begin
                    if (in_data && ki_s) begin
                        ko_d = 1'b0;
                        if (cls_ok) begin
                            sel_t_d = sel_val;
                            sel_f_d = ~sel_val;
                            op_t_d  = (cls == 2'b01);
                            op_f_d  = (cls == 2'b10);
                            cnt_d   = cnt_q + CNT_ONE;
                        end else begin
                            err_op_d = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (in_null && !ki_s) begin
                        sel_t_d = '0;
                        sel_f_d = '0;
                        op_t_d  = 1'b0;
                        op_f_d  = 1'b0;
                        ko_d    = 1'b1;
                    end
                end
                S_BAD: begin
                    if (in_null) ko_d = 1'b1;
                end
                default: begin
                    sel_t_d = '0;
                    sel_f_d = '0;
                    op_t_d  = 1'b0;
                    op_f_d  = 1'b0;
                    ko_d    = 1'b1;
                end
            endcase
        end
    end

    assign sel_t    = sel_t_q;
    assign sel_f    = sel_f_q;
    assign op_t     = op_t_q;
    assign op_f     = op_f_q;
    assign ko       = ko_q;
    assign err_rail = err_rail_q;
    assign err_op   = err_op_q;
    assign dec_cnt  = cnt_q;

endmodule

// File: tb/tb_ncl_dr_ctrl_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for ncl_dr_ctrl_decoder (OP_W=4, SEL_W=2, CNT_W=8, no input
// synchroniser). Directed vector table, hand-written corner sequences
// (counter wrap, asynchronous reset in DATA) and randomized traffic against
// a behavioural model of the handshake.
// ---------------------------------------------------------------------------
module tb_ncl_dr_ctrl_decoder;

    localparam int OP_W  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [OP_W-1:0]  in_t, in_f;
    logic             ki;
    logic             ko;
    logic [SEL_W-1:0] sel_t, sel_f;
    logic             op_t, op_f;
    logic             err_rail, err_op;
    logic [CNT_W-1:0] dec_cnt;

    int total = 0;
    int bad   = 0;

    ncl_dr_ctrl_decoder #(.OP_W(OP_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_t(in_t), .in_f(in_f), .ki(ki), .ko(ko),
        .sel_t(sel_t), .sel_f(sel_f), .op_t(op_t), .op_f(op_f),
        .err_rail(err_rail), .err_op(err_op), .dec_cnt(dec_cnt)
    );

    always #5 clk = ~clk;

    // Packed view of all outputs: {sel_t, sel_f, op_t, op_f, ko, err_rail, err_op, dec_cnt}
    function automatic logic [16:0] outs();
        return {sel_t, sel_f, op_t, op_f, ko, err_rail, err_op, dec_cnt};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs after a falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic [OP_W-1:0] t, input logic [OP_W-1:0] f, input logic k);
        in_t = t;
        in_f = f;
        ki   = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_t = '0;
        in_f = '0;
        ki   = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] t;
        logic [3:0] f;
        logic       k;
        logic [1:0] e_sel_t;
        logic [1:0] e_sel_f;
        logic       e_op_t;
        logic       e_op_f;
        logic       e_ko;
        logic       e_err_rail;
        logic       e_err_op;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // ---------------- behavioural model ----------------
    // m_phase: 0 waiting for DATA, 1 holding a decode, 2 rejected opcode awaiting NULL
    int         m_phase;
    logic       m_valid, m_op, m_ko, m_erail, m_eop;
    logic [1:0] m_sel;
    int         m_cnt;

    task automatic model_reset();
        m_phase = 0; m_valid = 0; m_op = 0; m_sel = 0;
        m_ko = 1; m_erail = 0; m_eop = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [3:0] t, input logic [3:0] f, input logic k);
        bit illegal, data, null_w;
        int v;
        illegal = ((t & f) != 0);
        data    = !illegal && ((t | f) == 4'hF);
        null_w  = ((t | f) == 4'h0);
        v       = int'(t);
        if (illegal) begin
            m_erail = 1;
        end else if (m_phase == 0 && data && k) begin
            m_ko = 0;
            if (v / 4 == 1 || v / 4 == 2) begin
                m_valid = 1;
                m_op    = (v / 4 == 1);
                m_sel   = 2'(v % 4);
                m_cnt   = (m_cnt + 1) % 256;
                m_phase = 1;
            end else begin
                m_eop   = 1;
                m_phase = 2;
            end
        end else if (m_phase == 1 && null_w && !k) begin
            m_valid = 0; m_ko = 1; m_phase = 0;
        end else if (m_phase == 2 && null_w) begin
            m_ko = 1; m_phase = 0;
        end
    endtask

    function automatic logic [16:0] model_outs();
        logic [1:0] st, sf;
        st = m_valid ? m_sel : 2'b00;
        sf = m_valid ? ~m_sel : 2'b00;
        return {st, sf, m_valid & m_op, m_valid & ~m_op, m_ko, m_erail, m_eop, 8'(m_cnt)};
    endfunction

    initial begin
        // ---------------- directed vector table ----------------
        //          t      f      k   sel_t  sel_f  opt opf ko erl eop cnt
        vecs.push_back('{4'b0000, 4'b0000, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 8'd0}); // idle NULL
        vecs.push_back('{4'b0000, 4'b0000, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 8'd0});
        vecs.push_back('{4'b1011, 4'b0100, 1, 2'b11, 2'b00, 0, 1, 0, 0, 0, 8'd1}); // decode 1011
        vecs.push_back('{4'b1011, 4'b0100, 1, 2'b11, 2'b00, 0, 1, 0, 0, 0, 8'd1}); // held
        vecs.push_back('{4'b0000, 4'b0000, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 8'd1}); // NULL
        vecs.push_back('{4'b0110, 4'b1001, 1, 2'b10, 2'b01, 1, 0, 0, 0, 0, 8'd2}); // decode 0110
        vecs.push_back('{4'b1001, 4'b0110, 1, 2'b10, 2'b01, 1, 0, 0, 0, 0, 8'd2}); // new DATA ignored
        vecs.push_back('{4'b1001, 4'b0110, 0, 2'b10, 2'b01, 1, 0, 0, 0, 0, 8'd2}); // ki=0 but not NULL
        vecs.push_back('{4'b1000, 4'b0000, 0, 2'b10, 2'b01, 1, 0, 0, 0, 0, 8'd2}); // partial NULL holds
        vecs.push_back('{4'b0000, 4'b0000, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 8'd2});
        vecs.push_back('{4'b1111, 4'b0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'd2}); // illegal class
        vecs.push_back('{4'b1111, 4'b0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'd2});
        vecs.push_back('{4'b0000, 4'b0000, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1, 8'd2}); // NULL exits, ki ignored
        for (int i = 0; i < 5; i++)
            vecs.push_back('{4'b1000, 4'b0000, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1, 8'd2}); // partial held
        vecs.push_back('{4'b1010, 4'b0010, 1, 2'b00, 2'b00, 0, 0, 1, 1, 1, 8'd2}); // bit1 double-high
        vecs.push_back('{4'b1000, 4'b0111, 1, 2'b00, 2'b11, 0, 1, 0, 1, 1, 8'd3}); // decode 1000
        vecs.push_back('{4'b1010, 4'b0111, 0, 2'b00, 2'b11, 0, 1, 0, 1, 1, 8'd3}); // illegal in DATA holds
        vecs.push_back('{4'b0000, 4'b0000, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 8'd3});
        vecs.push_back('{4'b0100, 4'b1011, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 8'd3}); // ki=0 holds in NULL
        vecs.push_back('{4'b0100, 4'b1011, 1, 2'b00, 2'b11, 1, 0, 0, 1, 1, 8'd4}); // decode 0100
        vecs.push_back('{4'b0000, 4'b0000, 0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 8'd4});

        do_reset();
        check("reset", outs(), {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});

        foreach (vecs[i]) begin
            step(vecs[i].t, vecs[i].f, vecs[i].k);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_sel_t, vecs[i].e_sel_f, vecs[i].e_op_t, vecs[i].e_op_f,
                   vecs[i].e_ko, vecs[i].e_err_rail, vecs[i].e_err_op, vecs[i].e_cnt});
        end

        // ---------------- counter wrap ----------------
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(4'b0111, 4'b1000, 1'b1);
            step(4'b0000, 4'b0000, 1'b0);
            if (i == 254) check("cnt_255", {9'd0, dec_cnt}, {9'd0, 8'd255});
        end
        check("cnt_wrap", {9'd0, dec_cnt}, 17'd0);

        // ---------------- asynchronous reset while in DATA ----------------
        step(4'b0101, 4'b1010, 1'b1);
        check("pre_rst_data", outs(), {2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});
        #2 rst = 1'b1;
        #1;
        check("async_rst", outs(), {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
        @(negedge clk);
        rst = 1'b0;

        // ---------------- randomized traffic vs. model ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] v, m, t, f;
            logic k;
            int kind;
            v    = 4'($urandom);
            m    = 4'($urandom);
            k    = 1'($urandom);
            kind = $urandom_range(0, 19);
            if (kind < 8)       begin t = v;     f = ~v;     end
            else if (kind < 14) begin t = 4'h0;  f = 4'h0;   end
            else if (kind < 19) begin t = v & m; f = ~v & m; end
            else                begin t = v | m; f = ~v | m; end
            step(t, f, k);
            model_step(t, f, k);
            check($sformatf("rand%0d", n), outs(), model_outs());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/ncl_dr_ctrl_decoder.md
Name: ncl_dr_ctrl_decoder

Overview:
- Parametrised, clocked successor of the CPU's dual-rail NCL opcode controller.
- Decodes a dual-rail opcode of configurable width into a dual-rail select field and a dual-rail operation flag.
- Adds a four-phase ki/ko handshake, explicit DATA/NULL state, illegal-rail and illegal-opcode detection, and a decode counter.
- Sits between the instruction register and the ALU control datapath.

Parameters:
OP_W, 4, opcode width in dual-rail bit pairs; must be >= SEL_W+2
SEL_W, 2, select field width in bits, taken directly below the 2-bit class field
CNT_W, 8, decode counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_t  in  OP_W  opcode true rails
in_f  in  OP_W  opcode false rails
ki  in  1  downstream request: 1 = ready for DATA, 0 = ready for NULL
ko  out  1  upstream request: 1 = ready for DATA, 0 = ready for NULL
sel_t  out  SEL_W  select true rails
sel_f  out  SEL_W  select false rails
op_t  out  1  op flag true rail
op_f  out  1  op flag false rail
err_rail  out  1  sticky: some bit had both rails high
err_op  out  1  sticky: illegal class decoded
dec_cnt  out  CNT_W  count of completed DATA decodes

Behaviour:
- Reset (async, rst=1): state S_NULL. All sel/op rails 0 (NULL), ko=1, err_rail=0, err_op=0, dec_cnt=0. All outputs registered.
- Input classification, per clock, on sampled inputs:
  - complete DATA: every bit has exactly one rail high.
  - complete NULL: all rails low.
  - partial: anything else with no bit having both rails high.
  - illegal: any bit has both rails high.
- Field positions:
  - class = bits [OP_W-1:OP_W-2].
  - select = bits [OP_W-3:OP_W-2-SEL_W].
  - Lower bits must complete but are ignored.
- Decode:
  - class 10 → op=0.
  - class 01 → op=1.
  - sel = select field, rail for rail.
  - class 00/11 → illegal opcode.
- S_NULL:
  - Outputs NULL, ko=1.
  - If complete DATA, ki=1 and class legal: next edge outputs decoded DATA, ko=0, dec_cnt+1 (wraps 2^CNT_W-1→0), go S_DATA.
  - If complete DATA, ki=1 and class illegal: outputs stay NULL, ko=0, err_op=1, go S_BAD.
  - Partial input or ki=0: hold (hysteresis).
- S_DATA:
  - Outputs held.
  - If complete NULL and ki=0: next edge outputs NULL, ko=1, go S_NULL.
  - A partial NULL (some rails still high) holds.
  - Input changes to a different DATA without an intervening NULL: ignored.
- S_BAD:
  - Outputs NULL, ko=0.
  - If complete NULL: ko=1, go S_NULL. ki is ignored.
- Illegal input, in any state: err_rail=1 next edge; state, outputs and ko hold while illegal; resume normal rules once the input becomes legal.
- Latency: 1 clock from the qualifying edge to the output and ko change.
- Outputs are never partial: all sel/op rails update on the same edge.
- err_rail and err_op clear only on rst.
- rst mid-operation: immediate return to reset values, including a NULL drive of the outputs.

Optional Feature:
- Macro NCL_IN_SYNC_EN.
- Defined: in_t, in_f and ki each pass through a 2-flop synchroniser (reset to 0) before classification. Latency becomes 3 clocks from input change to output/ko change.
- Undefined: inputs are used directly, with 1-clock latency as above. In this case inputs must be synchronous to clk.

Test Plan (defaults: OP_W=4, SEL_W=2):
- Reset then idle NULL with ki=1 → ko=1, all output rails 0, dec_cnt=0 indefinitely.
- ki=1, apply opcode 1011 (in_t=1011, in_f=0100) → next edge op_f=1, op_t=0, sel_t=11, sel_f=00, ko=0, dec_cnt=1. Apply NULL with ki=0 → next edge all outputs 0, ko=1.
- ki=1, opcode 0110 → op_t=1, sel_t=10, sel_f=01. While in S_DATA, change the input to 1001 without NULL → outputs unchanged.
- ki=1, opcode 1111 → outputs stay NULL, ko=0, err_op=1. Apply NULL → ko=1. err_op stays 1 until rst.
- ki=1, partial input (in_t=1000, in_f=0000) held 5 clocks → no state change, ko=1. Set in_t[1]=in_f[1]=1 → err_rail=1 and state held.
- Drive 256 legal DATA/NULL cycles with CNT_W=8 → dec_cnt wraps to 0. Assert rst while in S_DATA → outputs NULL and ko=1 without waiting for a clock edge.
